// File: rtl/aq_djpeg_pkg.sv
// Shared constants and types for the JPEG decoder front end.
// The stuffing-removal build option is AQ_DJPEG_FEEDER_UNSTUFF_EN.
package aq_djpeg_pkg;

    localparam int CNT_W     = 4;
    localparam int BUF_BYTES = 8;

    localparam logic [7:0]  M_FF  = 8'hFF;
    localparam logic [15:0] M_EOI = 16'hFFD9;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/aq_djpeg_unstuff4.sv
// Combinational compactor that drops 0x00 stuffing bytes after 0xFF in one
// 32-bit word and packs the kept bytes toward [31:24]. Used only when
// AQ_DJPEG_FEEDER_UNSTUFF_EN is defined.
module aq_djpeg_unstuff4
    import aq_djpeg_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic        ff_pend_in,
    input  logic        enable,
    output logic [31:0] packed_out,
    output logic [2:0]  keep_cnt,
    output logic        ff_pend_out
);

    logic [7:0] cur_byte;
    logic       prev_ff;

    always_comb begin
        packed_out = '0;
        keep_cnt   = '0;
        cur_byte   = '0;
        prev_ff    = ff_pend_in & enable;
        for (int i = 0; i < 4; i++) begin
            cur_byte = word_in[31-8*i -: 8];
            if (!(enable && prev_ff && (cur_byte == 8'h00))) begin
                packed_out = packed_out | ({cur_byte, 24'h0} >> {keep_cnt, 3'b000});
                keep_cnt   = keep_cnt + 3'd1;
            end
            // The raw previous byte decides stuffing, so a dropped 0x00 never counts as 0xFF.
            prev_ff = enable && (cur_byte == M_FF);
        end
        ff_pend_out = enable & (word_in[7:0] == M_FF);
    end

endmodule

// File: rtl/aq_djpeg_byte_feeder.sv
// Byte-aligned window feeder in front of the JPEG marker/header FSM.
// Optional 0xFF00 stuffing removal is built in when AQ_DJPEG_FEEDER_UNSTUFF_EN is defined.
module aq_djpeg_byte_feeder
    import aq_djpeg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        SoftClear,
    input  logic [31:0] InData,
    input  logic        InValid,
    output logic        InReady,
    input  logic        InLast,
    input  logic        ImageEnable,
    input  logic        UseByte,
    input  logic        UseWord,
    output logic        DataInEnable,
    output logic [31:0] DataIn,
    output logic        DataInEnd
);

    logic [63:0] buf_q, buf_d;
    cnt_t        cnt_q, cnt_d;
    logic        last_seen_q, last_seen_d;

    logic        accept;
    logic [1:0]  use_amt;
    cnt_t        consume;
    cnt_t        base;
    logic [31:0] load_bytes;
    logic [2:0]  load_cnt;

`ifdef AQ_DJPEG_FEEDER_UNSTUFF_EN
    logic ff_pend_q, ff_pend_d, ff_pend_next;

    aq_djpeg_unstuff4 u_unstuff (
        .word_in     (InData),
        .ff_pend_in  (ff_pend_q),
        .enable      (ImageEnable),
        .packed_out  (load_bytes),
        .keep_cnt    (load_cnt),
        .ff_pend_out (ff_pend_next)
    );

    always_comb begin
        ff_pend_d = ImageEnable ? ff_pend_q : 1'b0;
        if (accept) begin
            ff_pend_d = ff_pend_next;
        end
        if (SoftClear) begin
            ff_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff_pend_q <= 1'b0;
        end else begin
            ff_pend_q <= ff_pend_d;
        end
    end
`else
    logic unused_image_enable;

    assign load_bytes          = InData;
    assign load_cnt            = 3'd4;
    assign unused_image_enable = ImageEnable;
`endif

    // Accepting at cnt <= 4 guarantees a whole word always fits in the 8-byte buffer.
    assign InReady      = rst & ~SoftClear & ~last_seen_q & (cnt_q <= cnt_t'(BUF_BYTES / 2));
    assign DataInEnable = (cnt_q >= cnt_t'(4)) | (last_seen_q & (cnt_q != '0));
    assign DataIn       = buf_q[63:32];
    assign DataInEnd    = last_seen_q & (cnt_q == '0);

    always_comb begin
        use_amt = UseWord ? 2'd2 : (UseByte ? 2'd1 : 2'd0);
        consume = '0;
        if (DataInEnable) begin
            consume = (cnt_t'(use_amt) > cnt_q) ? cnt_q : cnt_t'(use_amt);
        end
        base        = cnt_q - consume;
        accept      = InValid & InReady;

        buf_d       = buf_q << {consume, 3'b000};
        cnt_d       = base;
        last_seen_d = last_seen_q;
        // New bytes land right after whatever survives this cycle's consume.
        if (accept) begin
            buf_d = buf_d | ({load_bytes, 32'h0} >> {base, 3'b000});
            cnt_d = base + cnt_t'(load_cnt);
            if (InLast) begin
                last_seen_d = 1'b1;
            end
        end
        if (SoftClear) begin
            buf_d       = '0;
            cnt_d       = '0;
            last_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q       <= '0;
            cnt_q       <= '0;
            last_seen_q <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            last_seen_q <= last_seen_d;
        end
    end

endmodule

// File: tb/tb_aq_djpeg_byte_feeder.sv
// Directed bench for aq_djpeg_byte_feeder with a byte scoreboard queue.
// Stuffing-removal steps run only when AQ_DJPEG_FEEDER_UNSTUFF_EN is defined.
module tb_aq_djpeg_byte_feeder;
    import aq_djpeg_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        SoftClear;
    logic [31:0] InData;
    logic        InValid;
    logic        InReady;
    logic        InLast;
    logic        ImageEnable;
    logic        UseByte;
    logic        UseWord;
    logic        DataInEnable;
    logic [31:0] DataIn;
    logic        DataInEnd;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [7:0] sb[$];

    aq_djpeg_byte_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .SoftClear    (SoftClear),
        .InData       (InData),
        .InValid      (InValid),
        .InReady      (InReady),
        .InLast       (InLast),
        .ImageEnable  (ImageEnable),
        .UseByte      (UseByte),
        .UseWord      (UseWord),
        .DataInEnable (DataInEnable),
        .DataIn       (DataIn),
        .DataInEnd    (DataInEnd)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] window();
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < sb.size()) w[31-8*i -: 8] = sb[i];
        end
        return w;
    endfunction

    task automatic pushWord(input logic [31:0] w);
        for (int i = 0; i < 4; i++) sb.push_back(w[31-8*i -: 8]);
    endtask

    task automatic softClear();
        SoftClear = 1'b1;
        InValid   = 1'b0;
        UseByte   = 1'b0;
        UseWord   = 1'b0;
        InLast    = 1'b0;
        step();
        SoftClear = 1'b0;
        sb.delete();
        #1;
    endtask

    // Consume one byte per cycle, comparing the window to the scoreboard each time.
    task automatic drainCheck(input string tag);
        int guard;
        guard   = 0;
        InValid = 1'b0;
        InLast  = 1'b0;
        UseWord = 1'b0;
        while (DataInEnable === 1'b1 && guard < 40) begin
            UseByte = 1'b1;
            #1;
            checkOutput({tag, "_win"}, DataIn, window());
            if (sb.size() > 0) void'(sb.pop_front());
            step();
            guard++;
        end
        UseByte = 1'b0;
        #1;
        if (guard >= 40) checkOutput({tag, "_timeout"}, 32'(guard), 32'd0);
        checkOutput({tag, "_left"}, 32'(sb.size()), 32'd0);
        checkOutput({tag, "_end"}, {31'b0, DataInEnd}, 32'd1);
        checkOutput({tag, "_endwin"}, DataIn, 32'h0);
    endtask

    // Hold InValid with incrementing words while consuming on alternate cycles.
    task automatic applyStimulus(input int cycles);
        logic [31:0] wordCtr;
        wordCtr = 32'h00010203;
        for (int i = 0; i < cycles; i++) begin
            InData  = wordCtr;
            InValid = 1'b1;
            UseByte = i[0];
            #1;
            checkOutput("stream_ready", {31'b0, InReady}, {31'b0, sb.size() <= 4});
            checkOutput("stream_en", {31'b0, DataInEnable}, {31'b0, sb.size() >= 4});
            checkOutput("stream_win", DataIn, window());
            if (UseByte && DataInEnable) void'(sb.pop_front());
            if (InReady) begin
                pushWord(wordCtr);
                wordCtr = wordCtr + 32'h04040404;
            end
            step();
        end
        InValid = 1'b0;
        UseByte = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0; SoftClear = 1'b0; InData = '0; InValid = 1'b0; InLast = 1'b0;
        ImageEnable = 1'b0; UseByte = 1'b0; UseWord = 1'b0;
        #1;
        checkOutput("rst_ready", {31'b0, InReady}, 32'd0);
        checkOutput("rst_en", {31'b0, DataInEnable}, 32'd0);
        checkOutput("rst_data", DataIn, 32'h0);
        checkOutput("rst_end", {31'b0, DataInEnd}, 32'd0);
        step(); step();
        rst = 1'b1;
        #1;
        checkOutput("post_rst_ready", {31'b0, InReady}, 32'd1);

        // Two header words loaded back to back fill the buffer.
        InData = 32'hFFD8FFE0; InValid = 1'b1;
        step();
        checkOutput("load1_data", DataIn, 32'hFFD8FFE0);
        checkOutput("load1_en", {31'b0, DataInEnable}, 32'd1);
        checkOutput("load1_ready", {31'b0, InReady}, 32'd1);
        InData = 32'h00104A46;
        step();
        InValid = 1'b0;
        #1;
        checkOutput("load2_data", DataIn, 32'hFFD8FFE0);
        checkOutput("load2_ready", {31'b0, InReady}, 32'd0);
        UseWord = 1'b1;
        step();
        checkOutput("word1_data", DataIn, 32'hFFE00010);
        checkOutput("word1_ready", {31'b0, InReady}, 32'd0);
        step();
        UseWord = 1'b0;
        #1;
        checkOutput("word2_data", DataIn, 32'h00104A46);
        checkOutput("word2_ready", {31'b0, InReady}, 32'd1);

        // SoftClear beats a simultaneous load and consume.
        SoftClear = 1'b1; InValid = 1'b1; InData = 32'hDEADBEEF; UseWord = 1'b1;
        #1;
        checkOutput("sc_ready", {31'b0, InReady}, 32'd0);
        step();
        SoftClear = 1'b0; InValid = 1'b0; UseWord = 1'b0;
        #1;
        checkOutput("sc_en", {31'b0, DataInEnable}, 32'd0);
        checkOutput("sc_data", DataIn, 32'h0);
        checkOutput("sc_ready_after", {31'b0, InReady}, 32'd1);
        checkOutput("sc_end", {31'b0, DataInEnd}, 32'd0);
        step();
        checkOutput("sc_not_accepted", DataIn, 32'h0);

        sb.delete();
        applyStimulus(40);
        #1;
        while (DataInEnable === 1'b1 && sb.size() > 0) begin
            UseByte = 1'b1;
            #1;
            checkOutput("flush_win", DataIn, window());
            void'(sb.pop_front());
            step();
        end
        UseByte = 1'b0;
        #1;
        checkOutput("flush_ready", {31'b0, InReady}, 32'd1);
        InData = 32'hA0A1A2A3; InValid = 1'b1; InLast = 1'b1;
        pushWord(32'hA0A1A2A3);
        step();
        InValid = 1'b0; InLast = 1'b0;
        #1;
        checkOutput("stream_last_ready", {31'b0, InReady}, 32'd0);
        drainCheck("stream_drain");
        checkOutput("after_last_ready", {31'b0, InReady}, 32'd0);

        // Single final word drained byte by byte.
        softClear();
        InData = 32'h11223344; InValid = 1'b1; InLast = 1'b1;
        step();
        InValid = 1'b0; InLast = 1'b0;
        #1;
        checkOutput("single_data0", DataIn, 32'h11223344);
        checkOutput("single_end0", {31'b0, DataInEnd}, 32'd0);
        UseByte = 1'b1;
        step();
        checkOutput("single_data1", DataIn, 32'h22334400);
        checkOutput("single_en1", {31'b0, DataInEnable}, 32'd1);
        step();
        checkOutput("single_data2", DataIn, 32'h33440000);
        step();
        checkOutput("single_data3", DataIn, 32'h44000000);
        checkOutput("single_en3", {31'b0, DataInEnable}, 32'd1);
        checkOutput("single_end3", {31'b0, DataInEnd}, 32'd0);
        step();
        UseByte = 1'b0;
        #1;
        checkOutput("single_data4", DataIn, 32'h0);
        checkOutput("single_en4", {31'b0, DataInEnable}, 32'd0);
        checkOutput("single_end4", {31'b0, DataInEnd}, 32'd1);

        // Both consume requests at cnt=3, then an overdrawn UseWord clamps.
        softClear();
        InData = 32'hAABBCCDD; InValid = 1'b1; InLast = 1'b1;
        step();
        InValid = 1'b0; InLast = 1'b0; UseByte = 1'b1;
        step();
        checkOutput("both_pre", DataIn, 32'hBBCCDD00);
        UseWord = 1'b1;
        step();
        UseByte = 1'b0;
        #1;
        checkOutput("both_data", DataIn, 32'hDD000000);
        checkOutput("both_en", {31'b0, DataInEnable}, 32'd1);
        checkOutput("both_end", {31'b0, DataInEnd}, 32'd0);
        step();
        UseWord = 1'b0;
        #1;
        checkOutput("clamp_data", DataIn, 32'h0);
        checkOutput("clamp_end", {31'b0, DataInEnd}, 32'd1);
        checkOutput("clamp_en", {31'b0, DataInEnable}, 32'd0);
        step();
        checkOutput("clamp_hold", {31'b0, DataInEnd}, 32'd1);

`ifdef AQ_DJPEG_FEEDER_UNSTUFF_EN
        softClear();
        ImageEnable = 1'b1;
        sb = '{8'h12, 8'hFF, 8'h34, 8'hFF, 8'hFF, 8'hD9};
        InData = 32'h12FF0034; InValid = 1'b1;
        step();
        checkOutput("unstuff_w1", DataIn, 32'h12FF3400);
        InData = {16'hFF00, M_EOI}; InLast = 1'b1;
        step();
        InValid = 1'b0; InLast = 1'b0;
        #1;
        checkOutput("unstuff_w2", DataIn, 32'h12FF34FF);
        drainCheck("unstuff");

        softClear();
        ImageEnable = 1'b0;
        pushWord(32'h12FF0034);
        pushWord({16'hFF00, M_EOI});
        InData = 32'h12FF0034; InValid = 1'b1;
        step();
        InData = {16'hFF00, M_EOI}; InLast = 1'b1;
        step();
        InValid = 1'b0; InLast = 1'b0;
        drainCheck("raw");

        softClear();
        ImageEnable = 1'b1;
        sb = '{8'hAA, 8'hAA, 8'hAA, 8'hFF, 8'hBB, 8'hCC, 8'hDD};
        InData = 32'hAAAAAAFF; InValid = 1'b1;
        step();
        InData = 32'h00BBCCDD; InLast = 1'b1;
        step();
        InValid = 1'b0; InLast = 1'b0;
        drainCheck("cross");
        ImageEnable = 1'b0;
`endif

        // Reset in the middle of a file discards everything.
        softClear();
        InData = 32'h55667788; InValid = 1'b1;
        step();
        InValid = 1'b0;
        #1;
        checkOutput("mid_loaded", DataIn, 32'h55667788);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_data", DataIn, 32'h0);
        checkOutput("mid_rst_ready", {31'b0, InReady}, 32'd0);
        step();
        rst = 1'b1;
        #1;
        checkOutput("mid_rel_en", {31'b0, DataInEnable}, 32'd0);
        checkOutput("mid_rel_data", DataIn, 32'h0);
        checkOutput("mid_rel_ready", {31'b0, InReady}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
